// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and scheduler state encoding.
package uart_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [2:0] {
        StArb,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StHold
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request searching upward from ptr_i+1.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               any_o
);

    logic [IdxW-1:0] cand_idx;
    logic            found;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand_idx = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand_idx = IdxW'((32'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter among NUM_REQ requesters with round-robin arbitration,
// packet locking via req_last and a hold timeout that drops a stalled packet owner.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned HOLD_TIMEOUT = 1024,
    localparam int unsigned IdxW        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [ByteW*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     tx_start,
    output logic [ByteW-1:0]         tx_data,
    input  logic                     tx_busy,
    output logic [IdxW-1:0]          grant_id,
    output logic                     active,
    output logic                     lock_timeout
);

    localparam int unsigned CntW = $clog2(HOLD_TIMEOUT + 1);

    sched_state_e    state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [ByteW-1:0] data_q, data_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_start_q, tx_start_d;
    logic            lock_timeout_q, lock_timeout_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IdxW-1:0]    arb_idx;
    logic               arb_any;
    logic               accept;
    logic [IdxW-1:0]    sel_idx;
    logic [ByteW-1:0]   sel_byte;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req_i(req_valid),
        .ptr_i(rr_ptr_q),
        .gnt_o(arb_gnt),
        .idx_o(arb_idx),
        .any_o(arb_any)
    );

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        data_d         = data_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        tx_start_d     = 1'b0;
        lock_timeout_d = 1'b0;
        req_ready      = '0;
        accept         = 1'b0;
        sel_idx        = arb_idx;
        sel_byte       = '0;

        unique case (state_q)
            StArb: begin
                // Never grant while reset is held or while the core is still draining a byte.
                if (!rst && !tx_busy && arb_any) begin
                    req_ready = arb_gnt;
                    accept    = 1'b1;
                    sel_idx   = arb_idx;
                    rr_ptr_d  = arb_idx;
                    grant_d   = arb_idx;
                end
            end
            StLaunch: state_d = StWaitBusy;
            StWaitBusy: begin
                if (tx_busy) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = last_q ? StArb : StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                // An accept on the limit cycle takes priority over the timeout.
                if (req_valid[grant_q]) begin
                    req_ready[grant_q] = 1'b1;
                    accept             = 1'b1;
                    sel_idx            = grant_q;
                end else if (cnt_q == CntW'(HOLD_TIMEOUT - 1)) begin
                    lock_timeout_d = 1'b1;
                    state_d        = StArb;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StArb;
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IdxW'(i)) sel_byte = req_data[i*ByteW +: ByteW];
        end

        if (accept) begin
            data_d     = sel_byte;
            last_d     = req_last[sel_idx];
            state_d    = StLaunch;
            tx_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StArb;
            rr_ptr_q       <= IdxW'(NUM_REQ - 1);
            grant_q        <= '0;
            data_q         <= '0;
            last_q         <= 1'b0;
            cnt_q          <= '0;
            tx_start_q     <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            data_q         <= data_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            tx_start_q     <= tx_start_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = data_q;
    assign grant_id     = grant_q;
    assign lock_timeout = lock_timeout_q;
    assign active       = (state_q != StArb);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized packet traffic
// compared against a packet-level round-robin reference and a simple UART busy model.
module tb_uart_tx_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned HT    = 8;
    localparam int unsigned DEPTH = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic [1:0]        grant_id;
    logic              active;
    logic              lock_timeout;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ(NREQ),
        .HOLD_TIMEOUT(HT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .active(active),
        .lock_timeout(lock_timeout)
    );

    int checks = 0;
    int failures = 0;

    // Per-requester byte queues: {last, byte}, plus the earliest cycle each item may be offered.
    logic [8:0]      mem   [NREQ][DEPTH];
    int              avail [NREQ][DEPTH];
    int              head  [NREQ];
    int              tail  [NREQ];
    int              exp_q [$];
    logic [NREQ-1:0] fire = '0;
    logic            rst_req = 1'b1;
    logic            prev_busy = 1'b0;
    int cyc = 0, busy_cnt = 0, busy_len = 3;
    int fall_cyc = -1, to_cyc = -1, to_count = 0;
    int mptr = NREQ - 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_item(input int r, input logic [7:0] b, input logic l, input int av);
        mem[r][tail[r]]   = {l, b};
        avail[r][tail[r]] = av;
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i] && cyc >= avail[i][head[i]]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = mem[i][head[i]][7:0];
                req_last[i]        = mem[i][head[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
    endtask

    // One clock: retire accepted bytes, advance the UART model, drive, then observe.
    task automatic step();
        logic fire_any;
        int   e;
        @(negedge clk);
        fire_any = |fire;
        for (int i = 0; i < NREQ; i++) if (fire[i]) head[i]++;
        if (tx_start) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt > 0);
        cyc++;
        drive();
        rst = rst_req;
        #1;
        if (prev_busy && !tx_busy) fall_cyc = cyc;
        prev_busy = tx_busy;
        if (lock_timeout) begin
            to_count++;
            to_cyc = cyc;
        end
        if (!rst) begin
            check("launch_follows_accept", tx_start, fire_any);
            check("ready_legal", $onehot0(req_ready) && ((req_ready & ~req_valid) == '0), 1);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", tx_start, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("launch_grant", grant_id, e / 256);
                    check("launch_data", tx_data, e % 256);
                end
            end
        end
        fire = rst ? '0 : (req_valid & req_ready);
    endtask

    task automatic do_reset(input bit keep_busy);
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        exp_q.delete();
        if (!keep_busy) busy_cnt = 0;
        fire    = '0;
        rst_req = 1'b1;
        step();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_active", active, 0);
        check("rst_lock_timeout", lock_timeout, 0);
        step();
        rst_req = 1'b0;
        step();
    endtask

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || busy_cnt != 0 || pending()) && n < maxc) begin
            step();
            n++;
        end
        check("drain_within_budget", n < maxc, 1);
        step();
        step();
        check("idle_after_drain", active, 0);
    endtask

    // Packet-level round robin: whole packets go out in pointer order over non-empty queues.
    task automatic model_rr();
        int h [NREQ];
        int pick;
        int c;
        bit done;
        for (int i = 0; i < NREQ; i++) h[i] = head[i];
        for (int guard = 0; guard < DEPTH * NREQ; guard++) begin
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
                c = (mptr + k) % NREQ;
                if (pick < 0 && h[c] < tail[c]) pick = c;
            end
            if (pick < 0) break;
            done = 1'b0;
            while (!done && h[pick] < tail[pick]) begin
                exp_q.push_back(pick * 256 + int'(mem[pick][h[pick]][7:0]));
                done = mem[pick][h[pick]][8];
                h[pick]++;
            end
            mptr = pick;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int npk;
        int len;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end

        // Single byte from requester 0.
        do_reset(0);
        push_item(0, 8'h55, 1'b1, 0);
        exp_q.push_back(8'h55);
        step();
        check("t1_ready_onehot0", req_ready, 4'b0001);
        step();
        check("t1_tx_start", tx_start, 1);
        check("t1_tx_data", tx_data, 8'h55);
        drain(40);

        // All four requesters, then a second round with the pointer left at 1.
        do_reset(0);
        for (int i = 0; i < NREQ; i++) push_item(i, 8'hA0 + 8'(i), 1'b1, 0);
        for (int i = 0; i < NREQ; i++) exp_q.push_back(i * 256 + 8'hA0 + i);
        drain(100);
        push_item(1, 8'hB1, 1'b1, 0);
        exp_q.push_back(256 + 8'hB1);
        drain(40);
        for (int i = 0; i < NREQ; i++) push_item(i, 8'hC0 + 8'(i), 1'b1, 0);
        exp_q.push_back(2 * 256 + 8'hC2);
        exp_q.push_back(3 * 256 + 8'hC3);
        exp_q.push_back(0 * 256 + 8'hC0);
        exp_q.push_back(1 * 256 + 8'hC1);
        drain(100);

        // Three-byte packet from requester 1 holds off requester 2.
        do_reset(0);
        push_item(1, 8'h11, 1'b0, 0);
        push_item(1, 8'h22, 1'b0, 0);
        push_item(1, 8'h33, 1'b1, 0);
        push_item(2, 8'h44, 1'b1, 0);
        exp_q.push_back(256 + 8'h11);
        exp_q.push_back(256 + 8'h22);
        exp_q.push_back(256 + 8'h33);
        exp_q.push_back(2 * 256 + 8'h44);
        drain(100);

        // Stalled owner: lock drops HOLD_TIMEOUT cycles after HOLD entry, requester 0 next.
        do_reset(0);
        push_item(3, 8'h7E, 1'b0, 0);
        push_item(0, 8'h01, 1'b1, cyc + 3);
        exp_q.push_back(3 * 256 + 8'h7E);
        exp_q.push_back(8'h01);
        to_count = 0;
        fall_cyc = -1;
        to_cyc   = -1;
        n = 0;
        while (to_count == 0 && n < 60) begin
            step();
            n++;
        end
        check("timeout_fired", to_count, 1);
        check("timeout_latency", to_cyc - fall_cyc, 9);
        step();
        check("timeout_pulse_width", lock_timeout, 0);
        drain(60);
        check("timeout_single", to_count, 1);

        // Owner's next byte arrives on the limit cycle: accept wins, no timeout.
        do_reset(0);
        push_item(3, 8'h7E, 1'b0, 0);
        push_item(3, 8'h5A, 1'b1, 1 << 30);
        exp_q.push_back(3 * 256 + 8'h7E);
        exp_q.push_back(3 * 256 + 8'h5A);
        to_count = 0;
        fall_cyc = -1;
        n = 0;
        while (fall_cyc < 0 && n < 40) begin
            step();
            n++;
        end
        check("boundary_fall_seen", fall_cyc >= 0, 1);
        avail[3][1] = fall_cyc + 8;
        drain(60);
        check("boundary_no_timeout", to_count, 0);

        // Reset in WAIT_DONE while the core stays busy.
        do_reset(0);
        busy_len = 40;
        push_item(0, 8'h66, 1'b1, 0);
        exp_q.push_back(8'h66);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        repeat (4) step();
        check("active_before_reset", active, 1);
        busy_cnt = 21;
        do_reset(1);
        busy_len = 3;
        push_item(0, 8'h77, 1'b1, 0);
        push_item(2, 8'h99, 1'b1, 0);
        exp_q.push_back(8'h77);
        exp_q.push_back(2 * 256 + 8'h99);
        n = 0;
        while (busy_cnt > 0 && n < 30) begin
            step();
            n++;
            if (tx_busy) begin
                check("no_ready_while_busy", req_ready, 0);
                check("no_start_while_busy", tx_start, 0);
            end
        end
        drain(80);

        // Randomized packet traffic against the packet-level reference.
        do_reset(0);
        mptr = NREQ - 1;
        for (int round = 0; round < 6; round++) begin
            busy_len = $urandom_range(3, 6);
            for (int r = 0; r < NREQ; r++) begin
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) push_item(r, 8'($urandom), b == len - 1, 0);
                end
            end
            model_rr();
            drain(600);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares a single UART byte transmitter among `NUM_REQ` requesters. It sits between the requesting logic and the UART core's `tx_start` / `tx_data_in` / `tx_busy` control port. Each byte is accepted through a valid/ready handshake and launched with a one-cycle start pulse. Multi-byte packets flagged with `req_last` hold the grant until done, with a lock timeout so a stalled owner cannot block the transmitter.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `HOLD_TIMEOUT`, default 1024: idle cycles in HOLD before the packet lock is dropped; must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte of requester i ends its packet.
- `req_ready`  out  NUM_REQ  byte of requester i accepted this cycle (combinational).
- `tx_start`  out  1  one-cycle launch pulse to the UART core.
- `tx_data`  out  8  byte to the UART core; stable from launch until the next accept.
- `tx_busy`  in  1  UART core busy.
- `grant_id`  out  $clog2(NUM_REQ)  current or last granted requester.
- `active`  out  1  state ≠ ARB.
- `lock_timeout`  out  1  one-cycle pulse when the HOLD timeout fires.

## Operation
- States:
  - ARB: wait for `tx_busy`=0 and any `req_valid`. The winner is the first valid requester searching from `rr_ptr+1` mod NUM_REQ.
    - `req_ready[winner]`=1 in that cycle.
    - Capture `tx_data`, `last_r`, `grant_id`; set `rr_ptr`←winner.
    - Go to LAUNCH.
  - LAUNCH: `tx_start`=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_busy`=1, go to WAIT_DONE.
  - WAIT_DONE: when `tx_busy`=0, go to ARB if `last_r`=1, else go to HOLD and clear the hold counter.
  - HOLD: only `grant_id` is eligible.
    - If `req_valid[grant_id]`: `req_ready[grant_id]`=1, capture the byte and `last_r`, go to LAUNCH.
    - Else the counter increments. At `HOLD_TIMEOUT`-1, pulse `lock_timeout` and go to ARB.
- `req_ready` is at most one-hot. It is zero outside ARB and HOLD, and zero whenever no byte is accepted.
- Other requesters' `req_valid` are ignored during a packet; they may stay asserted.
- Reset values:
  - state ARB, `rr_ptr`=NUM_REQ-1 (requester 0 has first priority).
  - `tx_start`=0, `tx_data`=0, `req_ready`=0, `grant_id`=0, `active`=0, `lock_timeout`=0, `last_r`=0, hold counter 0.
- Reset mid-frame: the scheduler returns to ARB. If the UART core is still busy, ARB waits for `tx_busy`=0 before granting, so no byte is launched onto a busy core.
- Unused `req_data` bytes of non-granted requesters are don't-care.

## Timing
- Accept at cycle T (ARB or HOLD):
  - `tx_start` high at T+1.
  - `tx_busy` is expected high at T+2 (the core latches on `tx_start`).
  - WAIT_DONE is entered at T+3.
- Next accept: the cycle after `tx_busy` is sampled low in WAIT_DONE; one cycle of ARB or HOLD decision, no extra bubble.
- ARB decision is single-cycle combinational over `req_valid`. Registered outputs update at the next edge.
- Hold counter width is $clog2(HOLD_TIMEOUT+1). It never wraps, because it is cleared on entering HOLD.
- Simultaneous events:
  - `req_valid[grant_id]` in the same cycle the counter reaches its limit: the accept wins and no timeout fires.
  - Reset asserted in any state overrides all others.

## Structure
- Package `uart_pkg`: state enum (ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, HOLD) and byte-width constant 8, shared with the UART core wrapper.
- Sub-module `rr_arbiter`: parameterised by NUM_REQ; inputs request vector and pointer; outputs one-hot grant plus index. Purely combinational.
- Scheduler top: FSM, data/last registers, hold counter, pointer register.

## Test plan
- Single requester 0 sends 0x55 with last=1 → `req_ready[0]` in the accept cycle, `tx_start` pulse the next cycle, `tx_data`=0x55; back to ARB after `tx_busy` falls.
- Requesters 0–3 all valid with single bytes 0xA0..0xA3 → launch order 0,1,2,3. A second round started with `rr_ptr`=1 → order 2,3,0,1.
- Requester 1 sends a 3-byte packet 0x11,0x22,0x33 (last on 0x33) while requester 2 is valid → all three bytes go out before any byte of requester 2.
- Requester 3 sends byte 0x7E with last=0, then goes silent; `HOLD_TIMEOUT`=8 → `lock_timeout` pulses 8 cycles after HOLD entry; requester 0 is granted next.
- Reset asserted in WAIT_DONE while a UART model holds `tx_busy`=1 for 20 more cycles → all outputs at reset values; no `tx_start` until `tx_busy` falls, then requester 0 is served.
